// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch front end: PC register, next-PC selection and exception state.
// Optional macro FETCH_CNT_EN adds a 32-bit fetch_count of sequential/branch PC advances.
module fetch_unit #(
  parameter int unsigned  N          = 64,
  parameter logic [N-1:0] RESET_PC   = '0,
  parameter logic [N-1:0] EXC_VECTOR = N'(64'hD8)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         PCSrc,
  input  logic [N-1:0] PCBranch,
  input  logic         Exc,
  input  logic [3:0]   ExcCause,
  input  logic         ERet,
  input  logic [31:0]  instr_rom,
  output logic [5:0]   imem_addr,
  output logic [31:0]  instr,
  output logic [N-1:0] PC,
  output logic         fetch_fault,
  output logic [N-1:0] EPC,
  output logic [3:0]   ECause,
  output logic         in_handler,
`ifdef FETCH_CNT_EN
  output logic [31:0]  fetch_count,
`endif
  output logic         double_fault
);

  logic [N-1:0] r_pc;
  logic [N-1:0] r_epc;
  logic [3:0]   r_ecause;
  logic         r_in_handler;
  logic         r_double_fault;

  logic         w_fault;
  logic         w_exc_take;
  logic         w_eret_take;
  logic [3:0]   w_cause;

  // The ROM holds 64 words, so any PC outside [0, 0xFF] or misaligned is a fetch fault.
  assign w_fault     = (r_pc[1:0] != 2'b00) || (r_pc[N-1:8] != '0);
  assign w_exc_take  = Exc || w_fault;
  assign w_eret_take = ERet && r_in_handler;
  assign w_cause     = w_fault ? 4'h1 : ExcCause;

  assign imem_addr    = r_pc[7:2];
  assign instr        = w_fault ? 32'h0 : instr_rom;
  assign PC           = r_pc;
  assign fetch_fault  = w_fault;
  assign EPC          = r_epc;
  assign ECause       = r_ecause;
  assign in_handler   = r_in_handler;
  assign double_fault = r_double_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_epc          <= '0;
      r_ecause       <= 4'h0;
      r_in_handler   <= 1'b0;
      r_double_fault <= 1'b0;
    end else begin
      r_double_fault <= 1'b0;
      if (w_exc_take) begin
        r_pc <= EXC_VECTOR;
        // A nested exception keeps the original return state and only flags the double fault.
        if (r_in_handler) begin
          r_double_fault <= 1'b1;
        end else begin
          r_epc        <= r_pc;
          r_ecause     <= w_cause;
          r_in_handler <= 1'b1;
        end
      end else if (w_eret_take) begin
        r_pc         <= r_epc;
        r_in_handler <= 1'b0;
      end else if (!stall) begin
        r_pc <= PCSrc ? PCBranch : r_pc + N'(4);
      end
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] r_fetch_count;
  logic        w_advance;

  assign w_advance   = !w_exc_take && !w_eret_take && !stall;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_advance) begin
      r_fetch_count <= r_fetch_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan sequences plus randomized stimulus against a model.
module tb_fetch_unit;

  localparam int unsigned N = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          PCSrc = 1'b0;
  logic [N-1:0]  PCBranch = '0;
  logic          Exc = 1'b0;
  logic [3:0]    ExcCause = 4'h0;
  logic          ERet = 1'b0;
  logic [31:0]   instr_rom;
  logic [5:0]    imem_addr;
  logic [31:0]   instr;
  logic [N-1:0]  PC;
  logic          fetch_fault;
  logic [N-1:0]  EPC;
  logic [3:0]    ECause;
  logic          in_handler;
  logic          double_fault;
`ifdef FETCH_CNT_EN
  logic [31:0]   fetch_count;
`endif

  logic [31:0] rom [64];
  assign instr_rom = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .PCBranch     (PCBranch),
    .Exc          (Exc),
    .ExcCause     (ExcCause),
    .ERet         (ERet),
    .instr_rom    (instr_rom),
    .imem_addr    (imem_addr),
    .instr        (instr),
    .PC           (PC),
    .fetch_fault  (fetch_fault),
    .EPC          (EPC),
    .ECause       (ECause),
    .in_handler   (in_handler),
`ifdef FETCH_CNT_EN
    .fetch_count  (fetch_count),
`endif
    .double_fault (double_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_epc;
  logic [3:0]  m_cause;
  logic        m_inh;
  logic        m_df;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_fault();
    return (m_pc % 64'd4 != 64'd0) || (m_pc >= 64'd256);
  endfunction

  // One clock edge of the architectural rules, applied to the inputs currently driven.
  task automatic model_step();
    bit          flt;
    logic [3:0]  cs;
    flt = m_fault();
    cs  = flt ? 4'h1 : ExcCause;
    m_df = 1'b0;
    if (reset) begin
      m_pc = 64'h0; m_epc = 64'h0; m_cause = 4'h0; m_inh = 1'b0; m_cnt = 32'h0;
    end else if (Exc || flt) begin
      if (m_inh) m_df = 1'b1;
      else begin
        m_epc = m_pc; m_cause = cs; m_inh = 1'b1;
      end
      m_pc = 64'hD8;
    end else if (ERet && m_inh) begin
      m_pc  = m_epc;
      m_inh = 1'b0;
    end else if (!stall) begin
      m_pc  = PCSrc ? PCBranch : m_pc + 64'd4;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all();
    check("pc", PC, m_pc);
    check("imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
    check("instr", 64'(instr), m_fault() ? 64'h0 : 64'(rom[m_pc[7:2]]));
    check("fetch_fault", 64'(fetch_fault), 64'(m_fault()));
    check("epc", EPC, m_epc);
    check("ecause", 64'(ECause), 64'(m_cause));
    check("in_handler", 64'(in_handler), 64'(m_inh));
    check("double_fault", 64'(double_fault), 64'(m_df));
`ifdef FETCH_CNT_EN
    check("fetch_count", 64'(fetch_count), 64'(m_cnt));
`endif
  endtask

  task automatic cyc(input bit rst, input bit stl, input bit br, input logic [63:0] tgt,
                     input bit ex, input logic [3:0] cs, input bit er);
    @(negedge clk);
    reset = rst; stall = stl; PCSrc = br; PCBranch = tgt;
    Exc = ex; ExcCause = cs; ERet = er;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 64'h0, 0, 4'h0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    m_pc = '0; m_epc = '0; m_cause = '0; m_inh = 1'b0; m_df = 1'b0; m_cnt = '0;

    // Reset and free-running fetch
    cyc(1, 0, 0, 64'h0, 0, 4'h0, 0);
    check("tp_rst_pc", PC, 64'h0);
    check("tp_rst_inh", 64'(in_handler), 64'h0);
    idle(3);
    check("tp_seq_pc", PC, 64'hC);
    check("tp_seq_addr", 64'(imem_addr), 64'h3);
    check("tp_seq_instr", 64'(instr), 64'(rom[3]));

    // Branch taken, then branch suppressed by stall
    idle(4);
    cyc(0, 0, 1, 64'h08, 0, 4'h0, 0);
    check("tp_br_pc", PC, 64'h08);
    idle(5);
    cyc(0, 1, 1, 64'h08, 0, 4'h0, 0);
    check("tp_stall_pc", PC, 64'h1C);

    // Exception entry and return
    cyc(0, 0, 1, 64'h10, 0, 4'h0, 0);
    cyc(0, 0, 0, 64'h0, 1, 4'h3, 0);
    check("tp_exc_pc", PC, 64'hD8);
    check("tp_exc_epc", EPC, 64'h10);
    check("tp_exc_cause", 64'(ECause), 64'h3);
    cyc(0, 0, 0, 64'h0, 0, 4'h0, 1);
    check("tp_eret_pc", PC, 64'h10);
    check("tp_eret_inh", 64'(in_handler), 64'h0);

    // Out-of-range branch target faults on fetch
    cyc(0, 0, 1, 64'h102, 0, 4'h0, 0);
    check("tp_ff", 64'(fetch_fault), 64'h1);
    check("tp_ff_instr", 64'(instr), 64'h0);
    idle(1);
    check("tp_ff_pc", PC, 64'hD8);
    check("tp_ff_cause", 64'(ECause), 64'h1);
    check("tp_ff_epc", EPC, 64'h102);

    // Nested exceptions
    cyc(1, 0, 0, 64'h0, 0, 4'h0, 0);
    cyc(0, 0, 1, 64'h20, 0, 4'h0, 0);
    cyc(0, 0, 0, 64'h0, 1, 4'h5, 0);
    cyc(0, 0, 0, 64'h0, 1, 4'h7, 0);
    check("tp_df_epc", EPC, 64'h20);
    check("tp_df_pulse", 64'(double_fault), 64'h1);
    idle(1);
    check("tp_df_clear", 64'(double_fault), 64'h0);
    cyc(0, 0, 0, 64'h0, 1, 4'h2, 1);
    check("tp_exc_eret_pc", PC, 64'hD8);
    check("tp_exc_eret_inh", 64'(in_handler), 64'h1);
    check("tp_exc_eret_cause", 64'(ECause), 64'h5);

    // Reset wins mid-handler with stall
    cyc(1, 1, 0, 64'h0, 0, 4'h0, 0);
    check("tp_rst2_pc", PC, 64'h0);
    check("tp_rst2_epc", EPC, 64'h0);
    check("tp_rst2_inh", 64'(in_handler), 64'h0);

    // Counter scenario: 5 fetches, 1 stall, 1 exception
    idle(5);
    cyc(0, 1, 0, 64'h0, 0, 4'h0, 0);
    cyc(0, 0, 0, 64'h0, 1, 4'h4, 0);
`ifdef FETCH_CNT_EN
    check("tp_count", 64'(fetch_count), 64'h5);
`endif

    // Sequential wrap off the end of the ROM
    cyc(1, 0, 0, 64'h0, 0, 4'h0, 0);
    cyc(0, 0, 1, 64'hFC, 0, 4'h0, 0);
    idle(1);
    check("tp_wrap_pc", PC, 64'h100);
    check("tp_wrap_ff", 64'(fetch_fault), 64'h1);
    idle(1);
    check("tp_wrap_epc", EPC, 64'h100);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [63:0] tgt;
      r = $urandom_range(0, 9);
      if (r < 7)      tgt = 64'({$urandom_range(0, 63), 2'b00});
      else if (r < 9) tgt = 64'($urandom_range(0, 255));
      else            tgt = {$urandom, $urandom};
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), tgt, ($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the single-cycle LEGv8 core with exceptions; sits directly upstream of the instruction ROM.
- Owns the PC register and next-PC selection: sequential, branch, exception vector, ERET.
- Drives the 6-bit word address into the 64-entry ROM and forwards the returned 32-bit word to decode.
- Holds the exception state: EPC, cause, in-handler flag and double-fault detection.

Parameters:
- N, 64, datapath and PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- EXC_VECTOR, 64'hD8, handler entry address; word-aligned and below 256.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; ignored when an exception is taken.
- PCSrc  in  1  take branch this cycle.
- PCBranch  in  N  branch target.
- Exc  in  1  external/decode exception raised for the current instruction.
- ExcCause  in  4  cause code accompanying Exc.
- ERet  in  1  return from exception.
- instr_rom  in  32  word returned by the ROM for imem_addr.
- imem_addr  out  6  ROM word address = PC[7:2].
- instr  out  32  instruction to decode; 32'h0 when fetch_fault=1, else instr_rom.
- PC  out  N  current PC.
- fetch_fault  out  1  combinational: PC[1:0]!=0 or PC[N-1:8]!=0.
- EPC  out  N  saved return PC.
- ECause  out  4  saved cause.
- in_handler  out  1  set while servicing an exception.
- double_fault  out  1  one-cycle pulse on an exception taken while in_handler=1.

Behaviour:
- Reset (synchronous, active-high):
  - PC=RESET_PC, EPC=0, ECause=0, in_handler=0, double_fault=0.
  - Reset wins over every other input in the same cycle, including mid-handler.
- Effective exception: exc_take = Exc | fetch_fault. Effective cause = 4'h1 when fetch_fault=1 (fetch fault wins over ExcCause), else ExcCause.
- Next-PC priority, highest first; only one source applies per edge:
  1. exc_take: PC <= EXC_VECTOR. Applies even if stall=1.
  2. ERet with in_handler=1: PC <= EPC; in_handler <= 0.
  3. stall: PC holds.
  4. PCSrc: PC <= PCBranch.
  5. Otherwise: PC <= PC + 4. Modulo 2^N, no saturation.
- ERet with in_handler=0 is ignored and falls through to rule 3/4/5.
- Exception capture:
  - exc_take with in_handler=0: EPC <= PC (the faulting instruction itself), ECause <= effective cause, in_handler <= 1.
  - exc_take with in_handler=1: EPC and ECause unchanged; PC <= EXC_VECTOR; double_fault=1 for exactly the following cycle.
  - exc_take together with ERet in the same cycle: exception wins; EPC/ECause are not overwritten because in_handler is still 1.
- double_fault is registered: 1 for one cycle after a nested exception, 0 otherwise.
- imem_addr, instr and fetch_fault are combinational from PC; zero-cycle latency to the ROM.
- PC+4 wrap from 0xFC to 0x100 raises fetch_fault on the next cycle. This is the required out-of-ROM detection.

Optional Feature:
- Macro: FETCH_CNT_EN.
- Defined:
  - Adds output fetch_count (32 bits), reset to 0.
  - Increments by 1 on each edge where PC advances by rule 4 or 5.
  - Does not increment on stall, exception or ERet edges.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free-running cycles, PCSrc=0 -> PC 0x0, 0x4, 0x8, 0xC; imem_addr 0,1,2,3; instr==instr_rom.
- At PC=0x1C, PCSrc=1, PCBranch=0x08 -> next PC=0x08. Repeat with stall=1 -> PC holds 0x1C, branch not taken.
- At PC=0x10, Exc=1, ExcCause=4'h3 -> PC=0xD8, EPC=0x10, ECause=3, in_handler=1. Then ERet=1 -> PC=0x10, in_handler=0.
- PCBranch=0x102, PCSrc=1 -> fetch_fault=1, instr=0. Next edge: PC=0xD8, ECause=1, EPC=0x102.
- While in_handler=1 with EPC=0x20, Exc=1 -> PC=0xD8, EPC stays 0x20, double_fault high exactly one cycle. Exc and ERet together -> exception wins.
- reset asserted while in_handler=1 and stall=1 -> next edge all outputs at reset values. With FETCH_CNT_EN: 5 sequential fetches, 1 stall, 1 exception -> fetch_count=5.
